imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 45 ++++
 rtl/imm_decode.sv | 85 ++++++++
 rtl/imm_gen_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generator pipeline: format codes, major
// opcode constants and the decoded entry carried through the elastic buffer.
package imm_gen_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6
  } fmt_e;

  // Major opcode, instr[6:2]
  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    fmt_e                fmt;
    logic                illegal;
  } entry_t;

  localparam entry_t ENTRY_RESET   = '{imm: {MAX_XLEN{1'b0}}, fmt: FMT_NONE, illegal: 1'b0};
  localparam entry_t ENTRY_ILLEGAL = '{imm: {MAX_XLEN{1'b0}}, fmt: FMT_NONE, illegal: 1'b1};

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MAX_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: raw instruction -> {imm, fmt, illegal}.
// Immediates are always built 64 bits wide; narrower XLEN takes the low bits.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic [31:0] instr,
  output entry_t      entry
);

  logic [4:0]          opc_s;
  logic [2:0]          f3_s;
  logic                is_shift_s;
  logic [31:0]         i_imm_s;
  logic [31:0]         s_imm_s;
  logic [31:0]         b_imm_s;
  logic [31:0]         u_imm_s;
  logic [31:0]         j_imm_s;
  logic [SHAMT_W-1:0]  shamt_s;
  logic [MAX_XLEN-1:0] shamt_ext_s;
  logic [MAX_XLEN-1:0] shamt_w_ext_s;
  logic                unused_s;

  assign opc_s      = instr[6:2];
  assign f3_s       = instr[14:12];
  assign is_shift_s = (f3_s == F3_SLL) || (f3_s == F3_SR);
  assign unused_s   = ^instr[1:0];

  assign i_imm_s = {{20{instr[31]}}, instr[31:20]};
  assign s_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm_s = {instr[31:12], 12'h000};
  assign j_imm_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // srai/srli carry funct7 bits above the shamt field; only the shamt survives
  assign shamt_s       = instr[20 +: SHAMT_W];
  assign shamt_ext_s   = {{(MAX_XLEN-SHAMT_W){1'b0}}, shamt_s};
  assign shamt_w_ext_s = {{(MAX_XLEN-5){1'b0}}, instr[24:20]};

  // Select format and immediate from the major opcode
  always_comb begin
    entry = ENTRY_ILLEGAL;
    case (opc_s)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        entry = '{imm: sext32(i_imm_s), fmt: FMT_I, illegal: 1'b0};
      end
      OPC_OP_IMM: begin
        if (is_shift_s) begin
          entry = '{imm: shamt_ext_s, fmt: FMT_SHIFT, illegal: 1'b0};
        end else begin
          entry = '{imm: sext32(i_imm_s), fmt: FMT_I, illegal: 1'b0};
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift_s) begin
            entry = '{imm: shamt_w_ext_s, fmt: FMT_SHIFT, illegal: 1'b0};
          end else begin
            entry = '{imm: sext32(i_imm_s), fmt: FMT_I, illegal: 1'b0};
          end
        end else begin
          entry = ENTRY_ILLEGAL;
        end
      end
      OPC_STORE: begin
        entry = '{imm: sext32(s_imm_s), fmt: FMT_S, illegal: 1'b0};
      end
      OPC_BRANCH: begin
        entry = '{imm: sext32(b_imm_s), fmt: FMT_B, illegal: 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        entry = '{imm: sext32(u_imm_s), fmt: FMT_U, illegal: 1'b0};
      end
      OPC_JAL: begin
        entry = '{imm: sext32(j_imm_s), fmt: FMT_J, illegal: 1'b0};
      end
      default: begin
        entry = ENTRY_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decode into a two-entry elastic buffer
// (main + skid) with a registered in_ready and synchronous flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal
);

  entry_t dec_s;
  entry_t main_r;
  entry_t main_nxt_s;
  entry_t skid_r;
  entry_t skid_nxt_s;
  logic   main_v_r;
  logic   main_v_nxt_s;
  logic   skid_v_r;
  logic   skid_v_nxt_s;
  logic   in_ready_nxt_s;
  logic   push_s;
  logic   pop_s;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .instr (instr),
    .entry (dec_s)
  );

  assign push_s = in_valid & in_ready & ~flush;
  assign pop_s  = main_v_r & out_ready;

  // Buffer next-state: skid refills main on pop; push lands in main if free
  always_comb begin
    main_nxt_s   = main_r;
    skid_nxt_s   = skid_r;
    main_v_nxt_s = main_v_r;
    skid_v_nxt_s = skid_v_r;
    if (flush) begin
      main_v_nxt_s = 1'b0;
      skid_v_nxt_s = 1'b0;
    end else if (pop_s) begin
      if (skid_v_r) begin
        main_nxt_s   = skid_r;
        skid_v_nxt_s = 1'b0;
      end else if (push_s) begin
        main_nxt_s = dec_s;
      end else begin
        main_v_nxt_s = 1'b0;
      end
    end else if (push_s) begin
      if (main_v_r) begin
        skid_nxt_s   = dec_s;
        skid_v_nxt_s = 1'b1;
      end else begin
        main_nxt_s   = dec_s;
        main_v_nxt_s = 1'b1;
      end
    end else begin
      main_v_nxt_s = main_v_r;
    end
    in_ready_nxt_s = ~skid_v_nxt_s;
  end

  // Storage and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r   <= ENTRY_RESET;
      skid_r   <= ENTRY_RESET;
      main_v_r <= 1'b0;
      skid_v_r <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      main_r   <= main_nxt_s;
      skid_r   <= skid_nxt_s;
      main_v_r <= main_v_nxt_s;
      skid_v_r <= skid_v_nxt_s;
      in_ready <= in_ready_nxt_s;
    end
  end

  assign out_valid   = main_v_r;
  assign out_imm     = main_r.imm[XLEN-1:0];
  assign out_fmt     = main_r.fmt;
  assign out_illegal = main_r.illegal;

endmodule
